// File: rtl/mod100_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one iterative mod-100 engine between NUM_REQ clients.
// Optional WAIT-state watchdog enabled by defining MOD_ARB_TIMEOUT_EN.
module mod100_rr_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  req_n,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [6:0]             rsp_remain,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   eng_start,
  output logic [15:0]            eng_n,
  input  logic                   eng_ready,
  input  logic                   eng_done,
  input  logic [6:0]             eng_remain
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned OP_W  = 16;
  localparam int unsigned REM_W = 7;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [NUM_REQ-1:0] grant_d, rsp_valid_d;
  logic [REM_W-1:0]   rsp_remain_d;
  logic               rsp_err_d, busy_d, eng_start_d;
  logic [OP_W-1:0]    eng_n_d;

  logic               found;
  logic [IDX_W-1:0]   pick, cand;
  logic [OP_W-1:0]    op_sel;

`ifdef MOD_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Round-robin search starting just after the last served requester
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    cand   = '0;
    op_sel = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(last_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick == IDX_W'(i)) op_sel = req_n[i*OP_W +: OP_W];
    end
  end

  // Next-state and next-output logic; outputs are computed for the state being entered
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    win_d        = win_q;
    op_d         = op_q;
    eng_n_d      = eng_n;
    grant_d      = '0;
    rsp_valid_d  = '0;
    rsp_remain_d = '0;
    rsp_err_d    = 1'b0;
    eng_start_d  = 1'b0;
`ifdef MOD_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (found && eng_ready) begin
          state_d       = S_ISSUE;
          win_d         = pick;
          op_d          = op_sel;
          grant_d[pick] = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d     = S_WAIT;
        eng_start_d = 1'b1;
        eng_n_d     = op_q;
`ifdef MOD_ARB_TIMEOUT_EN
        cnt_d       = '0;
`endif
      end
      S_WAIT: begin
        if (eng_done) begin
          state_d            = S_RESP;
          rsp_valid_d[win_q] = 1'b1;
          rsp_remain_d       = eng_remain;
        end
`ifdef MOD_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d            = S_RESP;
          rsp_valid_d[win_q] = 1'b1;
          rsp_err_d          = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        // no watchdog: hold here until the engine completes
`endif
      end
      S_RESP: begin
        last_d  = win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_q     <= IDX_W'(NUM_REQ - 1);
      win_q      <= '0;
      op_q       <= '0;
      grant      <= '0;
      rsp_valid  <= '0;
      rsp_remain <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      eng_start  <= 1'b0;
      eng_n      <= '0;
`ifdef MOD_ARB_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      win_q      <= win_d;
      op_q       <= op_d;
      grant      <= grant_d;
      rsp_valid  <= rsp_valid_d;
      rsp_remain <= rsp_remain_d;
      rsp_err    <= rsp_err_d;
      busy       <= busy_d;
      eng_start  <= eng_start_d;
      eng_n      <= eng_n_d;
`ifdef MOD_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mod100_rr_arbiter.sv
// Directed self-checking bench for mod100_rr_arbiter with a behavioural mod-100 engine stub.
module tb_mod100_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] req_n;
  logic [3:0]  grant, rsp_valid;
  logic [6:0]  rsp_remain;
  logic        rsp_err, busy, eng_start;
  logic [15:0] eng_n;
  logic        eng_ready, eng_done;
  logic [6:0]  eng_remain;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mod100_rr_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_n(req_n),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_remain(rsp_remain),
    .rsp_err(rsp_err), .busy(busy), .eng_start(eng_start), .eng_n(eng_n),
    .eng_ready(eng_ready), .eng_done(eng_done), .eng_remain(eng_remain)
  );

  // Engine stub: fixed latency after start, optional suppression of done
  int         eng_lat  = 5;
  bit         eng_mute = 1'b0;
  logic       eng_bsy;
  int         eng_cnt;
  logic [6:0] eng_val;

  always @(posedge clk) begin
    if (rst) begin
      eng_bsy  <= 1'b0;
      eng_done <= 1'b0;
      eng_cnt  <= 0;
      eng_val  <= '0;
    end else begin
      eng_done <= 1'b0;
      if (eng_start && !eng_bsy) begin
        eng_bsy <= 1'b1;
        eng_cnt <= eng_lat;
        eng_val <= 7'(eng_n % 16'd100);
      end else if (eng_bsy) begin
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1) begin
          eng_bsy  <= 1'b0;
          eng_done <= !eng_mute;
        end
      end
    end
  end
  assign eng_ready  = !eng_bsy;
  assign eng_remain = eng_done ? eng_val : 7'd0;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_cmp++;
    n_bad++;
    $error("FAIL %s: timed out waiting for DUT", tag);
  endtask

  task automatic wait_grant(input string tag);
    int k;
    k = 0;
    step();
    while (grant == '0 && k < 100) begin
      step();
      k++;
    end
    if (grant == '0) timeout_fail(tag);
  endtask

  // Called in the ISSUE cycle; returns on the first rsp_valid cycle
  task automatic wait_rsp(input string tag, output int wcyc, output int starts,
                          output int grants, output bit dprev, output logic [15:0] nstart);
    int k;
    int s_at;
    bit prev;
    k = 0; s_at = -1; prev = 1'b0;
    starts = 0; grants = 0; nstart = '0;
    step();
    while (rsp_valid == '0 && k < 200) begin
      if (eng_start) begin
        starts++;
        s_at   = k;
        nstart = eng_n;
      end
      if (grant != '0) grants++;
      prev = eng_done;
      step();
      k++;
    end
    if (rsp_valid == '0) timeout_fail(tag);
    dprev = prev;
    wcyc  = k - s_at;
  endtask

  task automatic serve(input string tag, input int i, input logic [15:0] n,
                       input logic [6:0] exp_rem, input bit exp_err, input int exp_wcyc);
    int wcyc, starts, grants;
    bit dprev;
    logic [15:0] nstart;
    req[i] = 1'b1;
    req_n[i*16 +: 16] = n;
    wait_grant({tag, "_grant_to"});
    chk({tag, "_grant"}, 32'(grant), 32'(4'b0001 << i));
    req[i] = 1'b0;
    wait_rsp({tag, "_rsp_to"}, wcyc, starts, grants, dprev, nstart);
    chk({tag, "_starts"}, 32'(starts), 32'd1);
    chk({tag, "_eng_n"}, 32'(nstart), 32'(n));
    chk({tag, "_valid"}, 32'(rsp_valid), 32'(4'b0001 << i));
    chk({tag, "_remain"}, 32'(rsp_remain), 32'(exp_rem));
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    chk({tag, "_done_prev"}, 32'(dprev), 32'(!exp_err));
    if (exp_wcyc >= 0) chk({tag, "_wait_cycles"}, 32'(wcyc), 32'(exp_wcyc));
    step();
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_valid_after"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_remain"}, 32'(rsp_remain), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_eng_start"}, 32'(eng_start), 32'd0);
    chk({tag, "_eng_n"}, 32'(eng_n), 32'd0);
  endtask

  initial begin
    int wcyc, starts, grants, seen;
    bit dprev;
    logic [15:0] nstart;
    int order [5];
    order = '{0, 1, 2, 3, 0};

    rst = 1'b1; req = '0; req_n = '0;
    step(); step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    // single request, 12345 mod 100 = 45
    serve("single", 0, 16'd12345, 7'd45, 1'b0, 7);

    // boundary operands from requester 1
    serve("b_zero",  1, 16'd0,     7'd0,  1'b0, 7);
    serve("b_99",    1, 16'd99,    7'd99, 1'b0, 7);
    serve("b_100",   1, 16'd100,   7'd0,  1'b0, 7);
    serve("b_65535", 1, 16'd65535, 7'd35, 1'b0, 7);

    // round-robin from a fresh reset: order 0,1,2,3,0
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) req_n[i*16 +: 16] = 16'(100*i + i);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant("rr_grant_to");
      chk("rr_grant", 32'(grant), 32'(4'b0001 << order[k]));
      req[order[k]] = 1'b0;
      if (k == 4) req = '0;
      wait_rsp("rr_rsp_to", wcyc, starts, grants, dprev, nstart);
      chk("rr_valid", 32'(rsp_valid), 32'(4'b0001 << order[k]));
      chk("rr_remain", 32'(rsp_remain), 32'(order[k]));
      if (k < 4) req[order[k]] = 1'b1;
    end
    step();
    chk("rr_busy_after", 32'(busy), 32'd0);

    // contention: requester 2 raises while requester 0 is in flight
    req[0] = 1'b1;
    req_n[15:0] = 16'd777;
    wait_grant("cont_g0_to");
    chk("cont_grant0", 32'(grant), 32'd1);
    req[0] = 1'b0;
    req[2] = 1'b1;
    req_n[47:32] = 16'd250;
    wait_rsp("cont_rsp0_to", wcyc, starts, grants, dprev, nstart);
    chk("cont_no_grant_busy", 32'(grants), 32'd0);
    chk("cont_valid0", 32'(rsp_valid), 32'd1);
    chk("cont_remain0", 32'(rsp_remain), 32'd77);
    wait_grant("cont_g2_to");
    chk("cont_grant2", 32'(grant), 32'd4);
    req[2] = 1'b0;
    wait_rsp("cont_rsp2_to", wcyc, starts, grants, dprev, nstart);
    chk("cont_valid2", 32'(rsp_valid), 32'd4);
    chk("cont_remain2", 32'(rsp_remain), 32'd50);
    step();

    // reset during WAIT aborts the request with no response
    req[0] = 1'b1;
    req_n[15:0] = 16'd5000;
    wait_grant("rstw_grant_to");
    req[0] = 1'b0;
    step(); step();
    chk("rstw_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    chk_reset_outputs("rstw");
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (rsp_valid != '0) seen++;
    end
    chk("rstw_no_rsp", 32'(seen), 32'd0);
    serve("rstw_next", 0, 16'd4321, 7'd21, 1'b0, 7);

`ifdef MOD_ARB_TIMEOUT_EN
    // watchdog: silent engine times out after 16 WAIT cycles
    eng_mute = 1'b1;
    serve("to_silent", 0, 16'd1234, 7'd0, 1'b1, 16);
    eng_mute = 1'b0;
    // done on the expiry cycle wins
    eng_lat = 14;
    serve("to_edge", 0, 16'd1234, 7'd34, 1'b0, 16);
    // done one cycle late is ignored
    eng_lat = 15;
    serve("to_late", 3, 16'd999, 7'd0, 1'b1, 16);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (rsp_valid != '0) seen++;
    end
    chk("to_late_ignored", 32'(seen), 32'd0);
    eng_lat = 5;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mod100_rr_arbiter.md
Name: mod100_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one iterative modulo-100 engine between NUM_REQ requesters. It latches the winning requester's 16-bit operand and issues a start pulse to the engine. It then waits for the engine's done pulse and returns the 7-bit remainder to that requester with a one-cycle valid. It sits between the client blocks and the single mod-100 engine instance; the engine shares clk/rst.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
TIMEOUT_CYC, 1024, watchdog limit in cycles for the WAIT state (used only with MOD_ARB_TIMEOUT_EN).

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
req  in  NUM_REQ  level request per requester; held until grant seen.
req_n  in  16*NUM_REQ  operands, requester i at bits [16*i+15:16*i]; stable while req[i]=1.
grant  out  NUM_REQ  one-hot, one-cycle pulse: operand captured.
rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: result for requester i.
rsp_remain  out  7  remainder; valid when any rsp_valid bit is set, else 0.
rsp_err  out  1  timeout flag, qualified by rsp_valid.
busy  out  1  high in any state except IDLE.
eng_start  out  1  one-cycle start pulse to engine.
eng_n  out  16  operand to engine, held from ISSUE until the next grant.
eng_ready  in  1  engine idle.
eng_done  in  1  engine one-cycle completion pulse.
eng_remain  in  7  engine result, valid while eng_done=1.

Behaviour:
- Reset values:
  - State IDLE.
  - grant=0, rsp_valid=0, rsp_remain=0, rsp_err=0, busy=0, eng_start=0, eng_n=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has priority first.
- Reset mid-operation aborts everything. No response is issued for the aborted request.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - Arbitration is allowed only if req!=0 and eng_ready=1.
  - Winner is the first set req bit searching last+1, last+2, ... modulo NUM_REQ.
  - Next cycle: grant[winner]=1, winner index and req_n slice latched, go to ISSUE.
  - eng_ready=0 blocks arbitration. The arbiter stays in IDLE.
- ISSUE: eng_start=1 for exactly one cycle, eng_n=latched operand, go to WAIT.
- WAIT:
  - Hold until eng_done=1.
  - Then latch eng_remain, go to RESP.
  - eng_done seen outside WAIT is ignored.
- RESP:
  - rsp_valid[winner]=1 and rsp_remain=latched value for one cycle.
  - Update last=winner, go to IDLE.
- Latency: req seen in IDLE at cycle t, then:
  - grant at t+1;
  - eng_start at t+2;
  - rsp_valid exactly one cycle after the eng_done cycle.
- Requester obligations:
  - Deassert req[i] the cycle after grant[i].
  - A req still high when the arbiter returns to IDLE is treated as a new request.
- A req dropped before grant is never served. No state is kept for it.
- Requests arriving while busy wait. No request is lost or reordered beyond round-robin order.
- Only one operation is in flight. Throughput is one result per (engine latency + 4) cycles minimum.
- rsp_remain is 7 bits, range 0..99. eng_remain is passed through unmodified.

Optional Feature:
MOD_ARB_TIMEOUT_EN
- Defined:
  - A counter (width clog2(TIMEOUT_CYC)) clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC-1 without eng_done, go to RESP with rsp_err=1 and rsp_remain=0.
  - eng_done in the same cycle as expiry wins: normal result, rsp_err=0.
  - A late eng_done after a timeout is ignored.
- Not defined: no counter; WAIT waits indefinitely; rsp_err is tied 0.

Test Plan:
1. Single request: req[0]=1 with n=12345, real engine -> grant[0] one cycle later, one eng_start, rsp_valid[0]=1 with rsp_remain=45, rsp_err=0, busy low afterwards.
2. Boundaries, run in sequence from requester 1 -> n=0 gives 0; 99 gives 99; 100 gives 0; 65535 gives 35.
3. Round-robin: req=4'b1111 held (each requester re-raises after its response) -> grant order 0,1,2,3,0; n_i=100*i+i gives remainders 0,1,2,3.
4. Contention while busy: requester 2 raises req during WAIT of requester 0 -> no grant until RESP completes; then grant[2] with a correct result.
5. Reset mid-WAIT: assert rst for 1 cycle -> all outputs 0; no rsp_valid for the aborted request; next req[0] is served normally.
6. With MOD_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, stub engine never pulses eng_done -> rsp_valid after 16 WAIT cycles with rsp_err=1, rsp_remain=0. Stub pulsing eng_done on the expiry cycle -> rsp_err=0 and the stub's value.
